// File: rtl/apb_arb_pkg.sv
// Shared types for the APB master arbiter: FSM state encoding and the latched request.
package apb_arb_pkg;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} arb_state_e;

  // Sized to the default widths; configs wider than this need these raised.
  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic                  write;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;
endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin picker: searches from last_grant+1 and remembers the winner when en is high.
module apb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               grant_any
);
  logic [IW-1:0] last_grant;
  logic          found;
  int            c;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    c         = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c = (int'(last_grant) + i) % NUM_REQ;
      if (!found && req[c]) begin
        found     = 1'b1;
        grant[c]  = en;
        grant_idx = IW'(c);
      end
    end
    grant_any = found && en;
  end

  // Reset to the top index so requester 0 is searched first.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        last_grant <= IW'(NUM_REQ-1);
    else if (grant_any) last_grant <= grant_idx;
  end
endmodule

// File: rtl/apb_mst_arbiter.sv
// Shares one APB master port across NUM_REQ requesters with round-robin grant.
// Optional ACCESS timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_mst_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_slverr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);
  localparam int IW = $clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  apb_req_t            lat;
  logic [IW-1:0]       owner;
  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       grant_idx;
  logic                accept, arb_en, done, tmo;
  logic [ADDR_W-1:0]   addr_a  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC+1);
  logic [CW-1:0] tcnt;

  // Held at zero outside ACCESS so every transfer starts a fresh count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 tcnt <= '0;
    else if (state_q != ACCESS)  tcnt <= '0;
    else if (!pready)            tcnt <= tcnt + CW'(1);
  end
  assign tmo = (state_q == ACCESS) && !pready && (tcnt == CW'(TIMEOUT_CYC-1));
`else
  assign tmo = 1'b0;
`endif

  assign done   = (state_q == ACCESS) && (pready || tmo);
  assign arb_en = resetn && ((state_q == IDLE) || done);

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .clk       (clk),
    .resetn    (resetn),
    .en        (arb_en),
    .req       (req_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (accept)
  );

  assign req_ready = grant;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    psel    = 1'b0;
    penable = 1'b0;
    case (state_q)
      IDLE:   if (accept) state_d = SETUP;
      SETUP:  begin
        psel    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (done) state_d = accept ? SETUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lat        <= '0;
      owner      <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (done) begin
        rsp_valid[owner] <= 1'b1;
        rsp_rdata        <= (lat.write || tmo) ? '0 : prdata;
        rsp_slverr       <= tmo ? 1'b1 : pslverr;
      end
      if (accept) begin
        lat.addr  <= APB_ADDR_W'(addr_a[grant_idx]);
        lat.write <= req_write[grant_idx];
        lat.wdata <= req_write[grant_idx] ? APB_DATA_W'(wdata_a[grant_idx]) : '0;
        owner     <= grant_idx;
      end
    end
  end

  assign paddr  = psel ? ADDR_W'(lat.addr)  : '0;
  assign pwdata = psel ? DATA_W'(lat.wdata) : '0;
  assign pwrite = psel && lat.write;
endmodule

// File: tb/tb_apb_mst_arbiter.sv
// Directed self-checking bench for apb_mst_arbiter (NUM_REQ=4, 32-bit APB).
module tb_apb_mst_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req_valid, req_ready, req_write, rsp_valid;
  logic [127:0] req_addr, req_wdata;
  logic [31:0] rsp_rdata, paddr, pwdata, prdata;
  logic        rsp_slverr, psel, penable, pwrite, pready, pslverr;
  int          tests_run = 0;
  int          fails = 0;

  apb_mst_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b1; pslverr = 1'b0;
    tick(); tick();
    tests_run++; if (psel !== 1'b0) begin fails++; $display("FAIL rst_psel got %0b exp 0", psel); end
    tests_run++; if (penable !== 1'b0) begin fails++; $display("FAIL rst_penable got %0b exp 0", penable); end
    tests_run++; if (rsp_valid !== 4'b0) begin fails++; $display("FAIL rst_rsp_valid got %b exp 0000", rsp_valid); end
    tests_run++; if (paddr !== 32'h0 || pwdata !== 32'h0 || pwrite !== 1'b0) begin fails++; $display("FAIL rst_pbus got %h/%h/%0b exp 0", paddr, pwdata, pwrite); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    req_valid = 4'b0001; req_write = 4'b0001; req_addr[31:0] = 32'h10; req_wdata[31:0] = 32'hA5A5_0001;
    pready = 1'b1;
    #1;
    tests_run++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL sw_ready got %b exp 0001", req_ready); end
    tick(); req_valid = '0;
    tests_run++; if (psel !== 1'b1 || penable !== 1'b0) begin fails++; $display("FAIL sw_setup got %0b%0b exp 10", psel, penable); end
    tests_run++; if (paddr !== 32'h10 || pwrite !== 1'b1 || pwdata !== 32'hA5A5_0001) begin fails++; $display("FAIL sw_bus got %h %0b %h exp 10 1 a5a50001", paddr, pwrite, pwdata); end
    tick();
    tests_run++; if (psel !== 1'b1 || penable !== 1'b1 || rsp_valid !== 4'b0) begin fails++; $display("FAIL sw_access got %0b%0b rv %b exp 11 rv 0000", psel, penable, rsp_valid); end
    tick();
    tests_run++; if (rsp_valid !== 4'b0001 || rsp_slverr !== 1'b0 || rsp_rdata !== 32'h0) begin fails++; $display("FAIL sw_rsp got %b %0b %h exp 0001 0 0", rsp_valid, rsp_slverr, rsp_rdata); end
    tests_run++; if (psel !== 1'b0 || penable !== 1'b0) begin fails++; $display("FAIL sw_idle got %0b%0b exp 00", psel, penable); end
    tick();
    tests_run++; if (rsp_valid !== 4'b0) begin fails++; $display("FAIL sw_pulse got %b exp 0000", rsp_valid); end
  endtask

  task automatic test_read_wait();
    req_valid = 4'b0100; req_write = 4'b0000; req_addr[95:64] = 32'h20; req_wdata[95:64] = 32'hFFFF_FFFF;
    prdata = 32'hDEAD_BEEF; pready = 1'b0;
    #1;
    tests_run++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL rd_ready got %b exp 0100", req_ready); end
    tick(); req_valid = '0;
    tests_run++; if (pwrite !== 1'b0 || pwdata !== 32'h0 || paddr !== 32'h20) begin fails++; $display("FAIL rd_setup got %0b %h %h exp 0 0 20", pwrite, pwdata, paddr); end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++; if (penable !== 1'b1 || paddr !== 32'h20 || rsp_valid !== 4'b0) begin fails++; $display("FAIL rd_wait%0d got pen %0b addr %h rv %b exp 1 20 0000", k, penable, paddr, rsp_valid); end
    end
    tick(); pready = 1'b1;
    tests_run++; if (penable !== 1'b1 || paddr !== 32'h20) begin fails++; $display("FAIL rd_last got pen %0b addr %h exp 1 20", penable, paddr); end
    tick();
    tests_run++; if (rsp_valid !== 4'b0100 || rsp_rdata !== 32'hDEAD_BEEF || rsp_slverr !== 1'b0) begin fails++; $display("FAIL rd_rsp got %b %h %0b exp 0100 deadbeef 0", rsp_valid, rsp_rdata, rsp_slverr); end
  endtask

  task automatic test_slverr();
    req_valid = 4'b0010; req_write = 4'b0010; req_addr[63:32] = 32'h30; req_wdata[63:32] = 32'h1;
    #1;
    tests_run++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL err_ready got %b exp 0010", req_ready); end
    tick(); req_valid = '0;
    tick(); pslverr = 1'b1;
    tick(); pslverr = 1'b0;
    tests_run++; if (rsp_valid !== 4'b0010 || rsp_slverr !== 1'b1) begin fails++; $display("FAIL err_rsp got %b %0b exp 0010 1", rsp_valid, rsp_slverr); end
    // Follow-up read from requester 3 must see a clean completion.
    req_valid = 4'b1000; req_write = 4'b0000; req_addr[127:96] = 32'h40; prdata = 32'h1234_5678;
    #1;
    tests_run++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL err_next_ready got %b exp 1000", req_ready); end
    tick(); req_valid = '0;
    tick(); tick();
    tests_run++; if (rsp_valid !== 4'b1000 || rsp_slverr !== 1'b0 || rsp_rdata !== 32'h1234_5678) begin fails++; $display("FAIL err_next_rsp got %b %0b %h exp 1000 0 12345678", rsp_valid, rsp_slverr, rsp_rdata); end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0010; req_write = 4'b0000; pready = 1'b0;
    tick(); req_valid = '0;
    tick();
    tests_run++; if (penable !== 1'b1) begin fails++; $display("FAIL rm_access got %0b exp 1", penable); end
    #3 resetn = 1'b0;
    #1;
    tests_run++; if (psel !== 1'b0 || penable !== 1'b0) begin fails++; $display("FAIL rm_async got %0b%0b exp 00", psel, penable); end
    pready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      tests_run++; if (rsp_valid !== 4'b0) begin fails++; $display("FAIL rm_no_rsp%0d got %b exp 0000", k, rsp_valid); end
    end
    resetn = 1'b1;
  endtask

  // Last grant before reset was 1, so a grant of 0 here proves the pointer reset.
  task automatic test_round_robin();
    req_valid = 4'b1111; req_write = 4'b1111;
    req_addr = {32'h300, 32'h200, 32'h100, 32'h000};
    pready = 1'b1;
    #1;
    tests_run++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL rr_first got %b exp 0001", req_ready); end
    tick();
    for (int k = 0; k < 5; k++) begin
      tests_run++; if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 32'((k % 4) * 32'h100)) begin fails++; $display("FAIL rr_setup%0d got %0b%0b %h exp 10 %h", k, psel, penable, paddr, (k % 4) * 32'h100); end
      if (k > 0) begin
        tests_run++; if (rsp_valid !== 4'(1 << ((k - 1) % 4))) begin fails++; $display("FAIL rr_rsp%0d got %b exp %b", k, rsp_valid, 4'(1 << ((k - 1) % 4))); end
      end
      tick();
      tests_run++; if (psel !== 1'b1 || penable !== 1'b1) begin fails++; $display("FAIL rr_access%0d got %0b%0b exp 11", k, psel, penable); end
      if (k == 4) begin req_valid = '0; #1; end
      tests_run++; if (req_ready !== ((k == 4) ? 4'b0 : 4'(1 << ((k + 1) % 4)))) begin fails++; $display("FAIL rr_grant%0d got %b", k, req_ready); end
      tick();
    end
    tests_run++; if (psel !== 1'b0 || rsp_valid !== 4'b0001) begin fails++; $display("FAIL rr_end got psel %0b rv %b exp 0 0001", psel, rsp_valid); end
  endtask

`ifdef APB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    req_valid = 4'b0001; req_write = 4'b0000; prdata = 32'hCAFE_F00D; pready = 1'b0;
    tick(); req_valid = '0;
    tick();
    for (int k = 1; k < 16; k++) tick();
    tests_run++; if (psel !== 1'b1 || penable !== 1'b1 || rsp_valid !== 4'b0) begin fails++; $display("FAIL to_last got %0b%0b rv %b exp 11 0000", psel, penable, rsp_valid); end
    tick();
    tests_run++; if (rsp_valid !== 4'b0001 || rsp_slverr !== 1'b1 || rsp_rdata !== 32'h0) begin fails++; $display("FAIL to_rsp got %b %0b %h exp 0001 1 0", rsp_valid, rsp_slverr, rsp_rdata); end
    tests_run++; if (psel !== 1'b0 || penable !== 1'b0) begin fails++; $display("FAIL to_idle got %0b%0b exp 00", psel, penable); end
    pready = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_slverr();
    test_reset_mid();
    test_round_robin();
`ifdef APB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
